regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Write-back scheduler for the 32x16 register file, which has two write ports taking {addr[4:0], data[15:0]} with an enable each.
- Arbitrates NUM_REQ write-back requesters (ALU, load unit, MAC, etc.) onto the two write ports with round-robin fairness.
- Resolves same-address collisions and drives registered port controls.
- Exports a pending-write mask so issue logic can detect read-after-write hazards on the cycle a write is in flight.

Parameters:
- NUM_REQ, 4, number of write-back requesters (verified at 4).
- ADDR_W, 5, register address width.
- DATA_W, 16, register data width.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iHold  in  1  high: no new grants this cycle.
- iReqValid  in  NUM_REQ  per-requester write request valid.
- iReqAddr  in  NUM_REQ*ADDR_W  packed destination addresses; requester k at [k*5+:5].
- iReqData  in  NUM_REQ*DATA_W  packed write data; requester k at [k*16+:16].
- oReqReady  out  NUM_REQ  combinational grant; a transfer occurs when valid&ready at a rising edge.
- oWritePort1  out  1  registered enable for write port 1.
- oWritePort2  out  1  registered enable for write port 2.
- oRegWrite1  out  21  registered {addr, data} for port 1.
- oRegWrite2  out  21  registered {addr, data} for port 2.
- oPendingMask  out  32  bit a set when either enabled output port holds address a.

Behaviour:
- Reset (iReset=0, async): oWritePort1/2=0, oRegWrite1/2=0, oPendingMask=0, rr pointer=0. Any in-flight write is discarded.
- Pointer: rr_ptr is a 2-bit register selecting the highest-priority requester. The search order is rr_ptr, rr_ptr+1, ... with modulo-NUM_REQ wrap.
- First grant (g0): the first valid requester in search order.
- Second grant (g1): the next valid requester after g0 whose address differs from g0's address.
  - A same-address requester is skipped and keeps its request.
  - Port 2 commits after port 1 in the regfile, so co-issuing two writes to one address is forbidden.
- Address 0 (r0 is hard-wired, not clocked):
  - An r0 request is granted normally (ready=1) and consumes a slot.
  - Its output enable is forced 0, so it sets no pending bit.
- iHold=1: oReqReady=0; on the next edge both output enables go 0 and rr_ptr is unchanged.
- Output stage on each edge:
  - oRegWrite1={addr,data} of g0; oWritePort1=(g0 exists)&&(addr!=0).
  - Same for g1 on port 2.
  - No grant: enable=0, data field holds its previous value.
- Latency: request accepted at edge N; enable visible N+1; regfile commits at edge N+1, so the value is readable from cycle N+1 onward after that edge.
- Pointer update on a grant edge: rr_ptr = (last granted index)+1 mod NUM_REQ, where last granted is g1 if present, else g0. With no grant, rr_ptr holds.
- oPendingMask: decoded combinationally from the output registers (onehot(addr1)&en1 | onehot(addr2)&en2). It is high exactly in the cycle the regfile holds the uncommitted write.
- Throughput: at most 2 writes/cycle. Every persistently valid requester is granted within ceil(NUM_REQ/2)+1 grant cycles with iHold low, including under address collisions.
- Requester contract: valid must stay high with addr/data stable until ready. The scheduler does not check this.
- Reset deasserted mid-stream: the first grant is computed from rr_ptr=0 on the first edge after release.

Decomposition:
- Shared package rf_pkg holds RF_ADDR_W=5, RF_DATA_W=16, RF_DEPTH=32, and the {addr,data} write-bus layout (field offsets 20:16 and 15:0) reused by regfile and pipeline.
- One sub-module, rr_pick2: combinational round-robin two-winner picker with address-collision masking (inputs: valid, addrs, rr_ptr; outputs: g0/g1 valid+index).
- Output registers, pointer and mask decode live in the top.

Test Plan:
- Reset with all valid=1 then release: before release, outputs and mask are 0 and ready is 0. On the first edge req0 (addr 3, 0x1111) and req1 (addr 4, 0x2222) are granted; next cycle oRegWrite1=0x31111, oRegWrite2=0x42222, both enables 1, mask=0x18.
- Fairness with all 4 valid, distinct addresses, held 4 cycles: grants alternate {0,1}, {2,3}, {0,1}, {2,3}, and rr_ptr cycles 0→2→0→2.
- Collision: req0 and req1 both addr 7, req2 addr 9, rr_ptr=0: g0=req0 and g1=req2, with req1 ready=0. Next grant cycle req1 is granted and port 1 writes addr 7; the regfile's final r7 equals req1 data.
- r0 write: only req2 valid with addr 0 → ready=1. Next cycle oWritePort1=0, mask=0, and rr_ptr becomes 3.
- iHold: with iHold=1 and all valid, ready=0 and enables drop to 0 the next cycle with rr_ptr frozen. After release, arbitration resumes from the frozen pointer.
- Async reset mid-operation: assert iReset low between edges while enables are 1 → enables, mask and rr_ptr are 0 immediately, without waiting for a clock edge, and the regfile receives no write.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry and the {addr, data} write-bus layout
// shared by the register file, the write-back scheduler and the pipeline.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 16;
  localparam int RF_DEPTH    = 32;
  localparam int RF_WBUS_W   = RF_ADDR_W + RF_DATA_W;

  // Write-bus field placement: address in [20:16], data in [15:0].
  localparam int WB_ADDR_LSB = 16;
  localparam int WB_DATA_LSB = 0;

  // Build a write-bus word from its address and data fields.
  function automatic logic [RF_WBUS_W-1:0] rf_wbus_pack(
    input logic [RF_ADDR_W-1:0] addr,
    input logic [RF_DATA_W-1:0] data
  );
    logic [RF_WBUS_W-1:0] bus;
    bus = '0;
    bus[WB_ADDR_LSB +: RF_ADDR_W] = addr;
    bus[WB_DATA_LSB +: RF_DATA_W] = data;
    return bus;
  endfunction

  // Extract the address field of a write-bus word.
  function automatic logic [RF_ADDR_W-1:0] rf_wbus_addr(
    input logic [RF_WBUS_W-1:0] bus
  );
    return bus[WB_ADDR_LSB +: RF_ADDR_W];
  endfunction

  // One-hot decode of a register address, qualified by an enable.
  function automatic logic [RF_DEPTH-1:0] rf_decode(
    input logic [RF_ADDR_W-1:0] addr,
    input logic                 en
  );
    logic [RF_DEPTH-1:0] hot;
    hot       = '0;
    hot[addr] = en;
    return hot;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin picker that selects up to two
// requesters per cycle. The second winner must target a different register
// than the first, because the two register-file ports commit in a fixed
// order and a same-cycle double write to one register is not allowed.
module rr_pick2
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ*ADDR_W-1:0] addrs,
  input  logic [IDX_W-1:0]          rr_ptr,
  output logic                      g0_valid,
  output logic [IDX_W-1:0]          g0_idx,
  output logic                      g1_valid,
  output logic [IDX_W-1:0]          g1_idx
);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  // Unpack the flat address bus into one entry per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = addrs[k*ADDR_W +: ADDR_W];
    end
  end

  // Walk requesters starting at rr_ptr; first valid wins port 1, the next
  // valid one with a different address wins port 2. Skipped same-address
  // requesters simply keep waiting.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] sel;
    logic [ADDR_W-1:0] g0_addr;
    g0_valid = 1'b0;
    g0_idx   = '0;
    g1_valid = 1'b0;
    g1_idx   = '0;
    g0_addr  = '0;
    pos      = 0;
    sel      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      sel = IDX_W'(pos);
      if (valid[sel]) begin
        if (!g0_valid) begin
          g0_valid = 1'b1;
          g0_idx   = sel;
          g0_addr  = addr_arr[sel];
        end else if (!g1_valid && (addr_arr[sel] != g0_addr)) begin
          g1_valid = 1'b1;
          g1_idx   = sel;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the write-back requesters onto the two
// register-file write ports with round-robin fairness, registers the port
// controls and exports a mask of registers with a write in flight.
module regfile_write_scheduler
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iHold,
  input  logic [NUM_REQ-1:0]        iReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] iReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] iReqData,
  output logic [NUM_REQ-1:0]        oReqReady,
  output logic                      oWritePort1,
  output logic                      oWritePort2,
  output logic [ADDR_W+DATA_W-1:0]  oRegWrite1,
  output logic [ADDR_W+DATA_W-1:0]  oRegWrite2,
  output logic [RF_DEPTH-1:0]       oPendingMask
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WBUS_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] req_addr [NUM_REQ];
  logic [DATA_W-1:0] req_data [NUM_REQ];

  logic              g0_valid;
  logic [IDX_W-1:0]  g0_idx;
  logic              g1_valid;
  logic [IDX_W-1:0]  g1_idx;
  logic              grant_go;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wr1_en_q, wr1_en_d;
  logic              wr2_en_q, wr2_en_d;
  logic [WBUS_W-1:0] wr1_q, wr1_d;
  logic [WBUS_W-1:0] wr2_q, wr2_d;

  // Successor of a requester index with wrap at NUM_REQ.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Unpack the flat request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr[k] = iReqAddr[k*ADDR_W +: ADDR_W];
      req_data[k] = iReqData[k*DATA_W +: DATA_W];
    end
  end

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid    (iReqValid),
    .addrs    (iReqAddr),
    .rr_ptr   (rr_ptr_q),
    .g0_valid (g0_valid),
    .g0_idx   (g0_idx),
    .g1_valid (g1_valid),
    .g1_idx   (g1_idx)
  );

  // No grants while held or while reset is asserted.
  assign grant_go = iReset && !iHold && g0_valid;

  // Ready is the combinational grant vector for this cycle.
  always_comb begin
    oReqReady = '0;
    if (grant_go) begin
      oReqReady[g0_idx] = 1'b1;
      if (g1_valid) begin
        oReqReady[g1_idx] = 1'b1;
      end
    end
  end

  // Next port contents and pointer; an idle port keeps its data field and
  // drops its enable. r0 writes take a slot but never enable a port.
  always_comb begin
    wr1_en_d = 1'b0;
    wr2_en_d = 1'b0;
    wr1_d    = wr1_q;
    wr2_d    = wr2_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_go) begin
      wr1_d    = rf_wbus_pack(req_addr[g0_idx], req_data[g0_idx]);
      wr1_en_d = (req_addr[g0_idx] != '0);
      rr_ptr_d = next_idx(g0_idx);
      if (g1_valid) begin
        wr2_d    = rf_wbus_pack(req_addr[g1_idx], req_data[g1_idx]);
        wr2_en_d = (req_addr[g1_idx] != '0);
        rr_ptr_d = next_idx(g1_idx);
      end
    end
  end

  // Port registers and round-robin pointer; reset discards any in-flight write.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      rr_ptr_q <= '0;
      wr1_en_q <= 1'b0;
      wr2_en_q <= 1'b0;
      wr1_q    <= '0;
      wr2_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr1_en_q <= wr1_en_d;
      wr2_en_q <= wr2_en_d;
      wr1_q    <= wr1_d;
      wr2_q    <= wr2_d;
    end
  end

  assign oWritePort1 = wr1_en_q;
  assign oWritePort2 = wr2_en_q;
  assign oRegWrite1  = wr1_q;
  assign oRegWrite2  = wr2_q;

  // Pending mask marks registers whose write is still uncommitted.
  assign oPendingMask = rf_decode(rf_wbus_addr(wr1_q), wr1_en_q)
                      | rf_decode(rf_wbus_addr(wr2_q), wr2_en_q);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Testbench for regfile_write_scheduler: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model of the
// arbitration rules plus a reference register file.
module tb_regfile_write_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 16;

  logic                      iClock = 1'b0;
  logic                      iReset;
  logic                      iHold;
  logic [NUM_REQ-1:0]        iReqValid;
  logic [NUM_REQ*ADDR_W-1:0] iReqAddr;
  logic [NUM_REQ*DATA_W-1:0] iReqData;
  logic [NUM_REQ-1:0]        oReqReady;
  logic                      oWritePort1;
  logic                      oWritePort2;
  logic [ADDR_W+DATA_W-1:0]  oRegWrite1;
  logic [ADDR_W+DATA_W-1:0]  oRegWrite2;
  logic [31:0]               oPendingMask;

  int testCount = 0;
  int failCount = 0;

  // Requester side: each requester holds its request until it is granted.
  bit          reqValid [NUM_REQ];
  logic [4:0]  reqAddr  [NUM_REQ];
  logic [15:0] reqData  [NUM_REQ];

  // Reference model state.
  int          mPtr;
  int          mG0;
  int          mG1;
  bit          mEn1;
  bit          mEn2;
  logic [20:0] mWb1;
  logic [20:0] mWb2;
  logic [3:0]  expReady;
  logic [3:0]  seenReady;
  logic [15:0] mRf     [32];
  logic [15:0] benchRf [32];

  regfile_write_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iHold        (iHold),
    .iReqValid    (iReqValid),
    .iReqAddr     (iReqAddr),
    .iReqData     (iReqData),
    .oReqReady    (oReqReady),
    .oWritePort1  (oWritePort1),
    .oWritePort2  (oWritePort2),
    .oRegWrite1   (oRegWrite1),
    .oRegWrite2   (oRegWrite2),
    .oPendingMask (oPendingMask)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 iClock = ~iClock;

  // Register file fed by the DUT ports; port 2 commits after port 1.
  always @(posedge iClock) begin
    if (oWritePort1) benchRf[oRegWrite1[20:16]] <= oRegWrite1[15:0];
    if (oWritePort2) benchRf[oRegWrite2[20:16]] <= oRegWrite2[15:0];
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int j, input bit v, input logic [4:0] a, input logic [15:0] d);
    reqValid[j] = v;
    reqAddr[j]  = a;
    reqData[j]  = d;
  endtask

  task automatic driveBus();
    for (int j = 0; j < NUM_REQ; j++) begin
      iReqValid[j]                 = reqValid[j];
      iReqAddr[j*ADDR_W +: ADDR_W] = reqAddr[j];
      iReqData[j*DATA_W +: DATA_W] = reqData[j];
    end
  endtask

  // Grants from the rules: list valid requesters in rotation order from the
  // pointer; the first wins, the next one with a different address also wins.
  task automatic modelPick();
    int order[$];
    mG0      = -1;
    mG1      = -1;
    expReady = '0;
    if (iReset && !iHold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (reqValid[(mPtr + k) % NUM_REQ]) order.push_back((mPtr + k) % NUM_REQ);
      end
      if (order.size() > 0) begin
        mG0 = order[0];
        for (int i = 1; i < order.size(); i++) begin
          if (mG1 < 0 && reqAddr[order[i]] != reqAddr[mG0]) mG1 = order[i];
        end
      end
    end
    if (mG0 >= 0) expReady[mG0] = 1'b1;
    if (mG1 >= 0) expReady[mG1] = 1'b1;
  endtask

  task automatic modelReset();
    mPtr = 0;
    mEn1 = 1'b0;
    mEn2 = 1'b0;
    mWb1 = '0;
    mWb2 = '0;
  endtask

  task automatic checkRegs(input string tag);
    logic [31:0] expMask;
    expMask = '0;
    if (mEn1) expMask[mWb1[20:16]] = 1'b1;
    if (mEn2) expMask[mWb2[20:16]] = 1'b1;
    checkOutput({tag, ".en1"},  32'(oWritePort1), 32'(mEn1));
    checkOutput({tag, ".en2"},  32'(oWritePort2), 32'(mEn2));
    checkOutput({tag, ".wb1"},  32'(oRegWrite1),  32'(mWb1));
    checkOutput({tag, ".wb2"},  32'(oRegWrite2),  32'(mWb2));
    checkOutput({tag, ".mask"}, oPendingMask,     expMask);
  endtask

  // One full cycle: drive at mid-low, check ready, clock, advance the model,
  // check the registered outputs, and return on the next falling edge.
  task automatic applyStimulus(input string tag, input bit dropGranted);
    driveBus();
    #1;
    modelPick();
    seenReady = oReqReady;
    checkOutput({tag, ".ready"}, 32'(oReqReady), 32'(expReady));
    @(posedge iClock);
    #1;
    if (mEn1) mRf[mWb1[20:16]] = mWb1[15:0];
    if (mEn2) mRf[mWb2[20:16]] = mWb2[15:0];
    mEn1 = 1'b0;
    mEn2 = 1'b0;
    if (mG0 >= 0) begin
      mWb1 = {reqAddr[mG0], reqData[mG0]};
      mEn1 = (reqAddr[mG0] != 5'd0);
      mPtr = (((mG1 >= 0) ? mG1 : mG0) + 1) % NUM_REQ;
    end
    if (mG1 >= 0) begin
      mWb2 = {reqAddr[mG1], reqData[mG1]};
      mEn2 = (reqAddr[mG1] != 5'd0);
    end
    checkRegs(tag);
    if (dropGranted) begin
      if (mG0 >= 0) reqValid[mG0] = 1'b0;
      if (mG1 >= 0) reqValid[mG1] = 1'b0;
    end
    @(negedge iClock);
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin
      mRf[a]     = '0;
      benchRf[a] = '0;
    end
    modelReset();
    iHold  = 1'b0;
    iReset = 1'b1;
    setReq(0, 1'b1, 5'd3, 16'h1111);
    setReq(1, 1'b1, 5'd4, 16'h2222);
    setReq(2, 1'b1, 5'd5, 16'h3333);
    setReq(3, 1'b1, 5'd6, 16'h4444);
    driveBus();
    #1;
    iReset = 1'b0;
    #2;

    // Held in reset with every requester valid.
    checkOutput("rst.ready", 32'(oReqReady),   32'h0);
    checkOutput("rst.en1",   32'(oWritePort1), 32'h0);
    checkOutput("rst.en2",   32'(oWritePort2), 32'h0);
    checkOutput("rst.wb1",   32'(oRegWrite1),  32'h0);
    checkOutput("rst.wb2",   32'(oRegWrite2),  32'h0);
    checkOutput("rst.mask",  oPendingMask,     32'h0);

    @(negedge iClock);
    iReset = 1'b1;

    // First grant after release, then fairness with all four held valid.
    applyStimulus("first", 1'b0);
    checkOutput("first.grant", 32'(seenReady),   32'h3);
    checkOutput("first.wb1",   32'(oRegWrite1),  32'h31111);
    checkOutput("first.wb2",   32'(oRegWrite2),  32'h42222);
    checkOutput("first.mask",  oPendingMask,     32'h18);
    applyStimulus("fair2", 1'b0);
    checkOutput("fair2.grant", 32'(seenReady), 32'hC);
    applyStimulus("fair3", 1'b0);
    checkOutput("fair3.grant", 32'(seenReady), 32'h3);
    applyStimulus("fair4", 1'b0);
    checkOutput("fair4.grant", 32'(seenReady), 32'hC);

    // Address collision: req1 shares r7 with req0 and must wait.
    setReq(0, 1'b1, 5'd7, 16'hAAAA);
    setReq(1, 1'b1, 5'd7, 16'hBBBB);
    setReq(2, 1'b1, 5'd9, 16'hCCCC);
    setReq(3, 1'b0, 5'd0, 16'h0000);
    applyStimulus("coll1", 1'b1);
    checkOutput("coll1.grant", 32'(seenReady), 32'h5);
    applyStimulus("coll2", 1'b1);
    checkOutput("coll2.grant", 32'(seenReady),  32'h2);
    checkOutput("coll2.wb1",   32'(oRegWrite1), 32'h7BBBB);
    applyStimulus("idle", 1'b1);
    checkOutput("coll.r7", 32'(benchRf[7]), 32'hBBBB);

    // r0 write takes a slot but enables nothing.
    setReq(2, 1'b1, 5'd0, 16'h5555);
    applyStimulus("r0", 1'b1);
    checkOutput("r0.grant", 32'(seenReady),   32'h4);
    checkOutput("r0.en1",   32'(oWritePort1), 32'h0);
    checkOutput("r0.mask",  oPendingMask,     32'h0);

    // Pointer after the r0 grant sits at requester 3.
    setReq(0, 1'b1, 5'd10, 16'h0A0A);
    setReq(1, 1'b1, 5'd11, 16'h0B0B);
    setReq(2, 1'b1, 5'd12, 16'h0C0C);
    setReq(3, 1'b1, 5'd13, 16'h0D0D);
    applyStimulus("ptr3", 1'b0);
    checkOutput("ptr3.grant", 32'(seenReady), 32'h9);

    // Hold freezes grants and the pointer.
    iHold = 1'b1;
    applyStimulus("hold", 1'b0);
    checkOutput("hold.grant", 32'(seenReady),   32'h0);
    checkOutput("hold.en1",   32'(oWritePort1), 32'h0);
    checkOutput("hold.en2",   32'(oWritePort2), 32'h0);
    iHold = 1'b0;
    applyStimulus("unhold", 1'b0);
    checkOutput("unhold.grant", 32'(seenReady), 32'h6);

    // Asynchronous reset while both ports are enabled.
    #2;
    iReset = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.en1",   32'(oWritePort1), 32'h0);
    checkOutput("arst.en2",   32'(oWritePort2), 32'h0);
    checkOutput("arst.mask",  oPendingMask,     32'h0);
    checkOutput("arst.ready", 32'(oReqReady),   32'h0);
    @(posedge iClock);
    @(negedge iClock);
    for (int j = 0; j < NUM_REQ; j++) reqData[j] = 16'h7000 + 16'(j);
    iReset = 1'b1;
    checkOutput("arst.r11", 32'(benchRf[11]), 32'h0);
    checkOutput("arst.r12", 32'(benchRf[12]), 32'h0);
    applyStimulus("arst.first", 1'b0);
    checkOutput("arst.grant", 32'(seenReady), 32'h3);

    // Randomized traffic with a small address range to provoke collisions.
    for (int j = 0; j < NUM_REQ; j++) reqValid[j] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iHold = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!reqValid[j] && $urandom_range(0, 1) == 1) begin
          setReq(j, 1'b1, 5'($urandom_range(0, 7)), 16'($urandom));
        end
      end
      applyStimulus("rand", 1'b1);
    end

    // Drain and compare the register files.
    iHold = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) reqValid[j] = 1'b0;
    applyStimulus("drain1", 1'b1);
    applyStimulus("drain2", 1'b1);
    for (int a = 0; a < 32; a++) begin
      checkOutput($sformatf("rf[%0d]", a), 32'(benchRf[a]), 32'(mRf[a]));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
